// File: rtl/seg_scan_n.sv
// rtl/seg_scan_n.sv - N-digit multiplexed seven-segment scanner with dp, leading-zero blanking, blink and guard.
module seg_scan_n #(
  parameter int N         = 4,
  parameter int DWELL     = 200000,
  parameter int GUARD     = 1000,
  parameter int BLINK_DIV = 128
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [4*N-1:0] digits,
  input  logic [N-1:0]   dp_en,
  input  logic           lz_en,
  input  logic [N-1:0]   blink_mask,
  output logic [N-1:0]   ena,
  output logic [7:0]     light
);

  localparam int CW = $clog2(DWELL);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int NP = 1 << IW;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DWELL - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(N - 1);
  localparam logic [BW-1:0] BCNT_MAX = BW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          bph_q, bph_d;
  logic [N-1:0]  ena_q, ena_d;
  logic [7:0]    light_q, light_d;

  logic            tick, guard_ok, visible, sup_cur, dp_cur;
  logic [3:0]      cur;
  logic [NP-1:0]   dp_pad, bm_pad, sup_pad;
  logic [4*NP-1:0] dig_pad;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 7'h3F;
      4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;
      4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;
      4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;
      4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;
      4'h9: decode = 7'h6F;
      4'hA: decode = 7'h77;
      4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;
      4'hD: decode = 7'h5E;
      4'hE: decode = 7'h79;
      default: decode = 7'h71;
    endcase
  endfunction

  if (GUARD == 0) begin : g_no_guard
    assign guard_ok = 1'b1;
  end else begin : g_guard
    assign guard_ok = (cnt_q >= CW'(GUARD));
  end

  // A digit is blanked when it and every more-significant digit are zero.
  always_comb begin : suppress
    logic az;
    az      = 1'b1;
    sup_pad = '0;
    for (int i = N - 1; i >= 0; i--) begin
      az         = az & (digits[4*i +: 4] == 4'd0);
      sup_pad[i] = lz_en & az & (i != 0);
    end
  end

  always_comb begin
    dp_pad          = '0;
    bm_pad          = '0;
    dig_pad         = '0;
    dp_pad[N-1:0]   = dp_en;
    bm_pad[N-1:0]   = blink_mask;
    dig_pad[4*N-1:0] = digits;
  end

  always_comb begin
    tick    = (cnt_q == CNT_MAX);
    cnt_d   = tick ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    bph_d   = bph_q;
    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
      if (bcnt_q == BCNT_MAX) begin
        bcnt_d = '0;
        bph_d  = ~bph_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end

    cur     = dig_pad[4*idx_q +: 4];
    sup_cur = sup_pad[idx_q];
    dp_cur  = dp_pad[idx_q];
    visible = guard_ok & ~(bm_pad[idx_q] & bph_q) & (~sup_cur | dp_cur);

    ena_d = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IW'(i)) ena_d[i] = visible;
    end
    light_d = visible ? {dp_cur, (sup_cur ? 7'd0 : decode(cur))} : 8'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      bph_q   <= 1'b0;
      ena_q   <= '0;
      light_q <= 8'd0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      bph_q   <= bph_d;
      ena_q   <= ena_d;
      light_q <= light_d;
    end
  end

  assign ena   = ena_q;
  assign light = light_q;

endmodule

// File: tb/tb_seg_scan_n.sv
// tb/tb_seg_scan_n.sv - self-checking bench for seg_scan_n (N=4 and N=1 instances).
module tb_seg_scan_n;

  localparam int DWELL = 8;
  localparam int GUARD = 2;
  localparam int BDIV  = 2;

  localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] dg;
  logic [3:0]  dp, bm, ena;
  logic        lz;
  logic [7:0]  light;
  logic [3:0]  dg1;
  logic        dp1, bm1, lz1, ena1;
  logic [7:0]  light1;

  int n_cmp = 0;
  int n_bad = 0;
  int t     = 0;

  typedef struct {
    logic [15:0] dg;
    logic [3:0]  dp;
    logic        lz;
    logic [3:0]  bm;
    logic [31:0] l;
  } vec_t;
  vec_t tbl [8];

  seg_scan_n #(.N(4), .DWELL(DWELL), .GUARD(GUARD), .BLINK_DIV(BDIV)) dut (
    .clk(clk), .rst(rst), .digits(dg), .dp_en(dp), .lz_en(lz),
    .blink_mask(bm), .ena(ena), .light(light)
  );

  seg_scan_n #(.N(1), .DWELL(DWELL), .GUARD(0), .BLINK_DIV(BDIV)) dut1 (
    .clk(clk), .rst(rst), .digits(dg1), .dp_en(dp1), .lz_en(lz1),
    .blink_mask(bm1), .ena(ena1), .light(light1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
    end
  endtask

  // Reference: derive dwell position, digit and blink phase from elapsed edges.
  function automatic void model(input int tt, input int n, input int guard,
                                input logic [31:0] d, input logic [7:0] dpv, input logic lzv,
                                input logic [7:0] bmv, output logic [7:0] e, output logic [7:0] l);
    int cnt, k, idx;
    logic bph, sup;
    logic [3:0] v;
    logic [63:0] hi;
    cnt = tt % DWELL;
    k   = tt / DWELL;
    idx = k % n;
    bph = ((k / BDIV) % 2) == 1;
    v   = 4'((d >> (4 * idx)) & 32'hF);
    hi  = ({32'b0, d} & ((64'd1 << (4 * n)) - 64'd1)) >> (4 * idx);
    sup = lzv && (idx >= 1) && (hi == 64'd0);
    e = 8'd0;
    l = 8'd0;
    if (cnt >= guard && !(bmv[idx] && bph) && (!sup || dpv[idx])) begin
      e = 8'(1 << idx);
      l = {dpv[idx], (sup ? 7'd0 : SEG[v])};
    end
  endfunction

  task automatic step();
    logic [7:0] e, l;
    @(posedge clk);
    #1;
    if (rst) begin
      check("rst_ena", 32'(ena), 32'd0);
      check("rst_light", 32'(light), 32'd0);
      check("rst_ena1", 32'(ena1), 32'd0);
      check("rst_light1", 32'(light1), 32'd0);
      t = 0;
    end else begin
      model(t, 4, GUARD, {16'b0, dg}, {4'b0, dp}, lz, {4'b0, bm}, e, l);
      check("model_ena", 32'(ena), 32'(e));
      check("model_light", 32'(light), 32'(l));
      model(t, 1, 0, {28'b0, dg1}, {7'b0, dp1}, lz1, {7'b0, bm1}, e, l);
      check("model_ena1", 32'(ena1), 32'(e));
      check("model_light1", 32'(light1), 32'(l));
      t++;
    end
  endtask

  initial begin
    int tt, slot;
    logic [7:0] el;
    logic [3:0] ee;
    dg = '0; dp = '0; bm = '0; lz = 1'b0;
    dg1 = '0; dp1 = 1'b0; bm1 = 1'b0; lz1 = 1'b0;

    // Expected light per slot, slot 0 in the low byte, first scan only.
    tbl[0] = '{16'h4321, 4'b0000, 1'b0, 4'b0000, 32'h664F5B06};
    tbl[1] = '{16'hFEDA, 4'b0010, 1'b0, 4'b0000, 32'h7179DE77};
    tbl[2] = '{16'h0050, 4'b0000, 1'b1, 4'b0000, 32'h00006D3F};
    tbl[3] = '{16'h0050, 4'b1000, 1'b1, 4'b0000, 32'h80006D3F};
    tbl[4] = '{16'h0000, 4'b0000, 1'b1, 4'b0000, 32'h0000003F};
    tbl[5] = '{16'h8888, 4'b1111, 1'b0, 4'b1111, 32'h0000FFFF};
    tbl[6] = '{16'h1000, 4'b0000, 1'b1, 4'b0000, 32'h063F3F3F};
    tbl[7] = '{16'h0B0C, 4'b0001, 1'b1, 4'b0000, 32'h007C3FB9};

    for (int r = 0; r < 8; r++) begin
      rst = 1'b1;
      step();
      dg = tbl[r].dg; dp = tbl[r].dp; lz = tbl[r].lz; bm = tbl[r].bm;
      dg1 = 4'(r * 3); dp1 = (r >= 4); bm1 = (r % 2 == 1); lz1 = 1'b1;
      rst = 1'b0;
      for (int s = 0; s < 32; s++) begin
        step();
        tt   = t - 1;
        slot = tt / DWELL;
        el   = ((tt % DWELL) < GUARD) ? 8'd0 : 8'((tbl[r].l >> (8 * slot)) & 32'hFF);
        ee   = (el != 8'd0) ? 4'(1 << slot) : 4'd0;
        check("tbl_ena", 32'(ena), 32'(ee));
        check("tbl_light", 32'(light), 32'(el));
      end
    end

    // Mid-dwell reset at idx=2, cnt=5, then restart gap.
    rst = 1'b1;
    step();
    dg = 16'h4321; dp = '0; lz = 1'b0; bm = '0;
    dg1 = 4'h7; dp1 = 1'b0; bm1 = 1'b0; lz1 = 1'b0;
    rst = 1'b0;
    for (int s = 0; s < 21; s++) step();
    check("pre_rst_ena", 32'(ena), 32'h4);
    rst = 1'b1;
    step();
    check("mid_rst_ena", 32'(ena), 32'd0);
    check("mid_rst_light", 32'(light), 32'd0);
    rst = 1'b0;
    step();
    check("gap0_ena", 32'(ena), 32'd0);
    check("n1_first_ena", 32'(ena1), 32'd1);
    check("n1_first_light", 32'(light1), 32'h07);
    step();
    check("gap1_ena", 32'(ena), 32'd0);
    step();
    check("first_ena", 32'(ena), 32'd1);
    check("first_light", 32'(light), 32'h06);

    // Random inputs and occasional resets against the reference model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) rst = 1'b1;
      else if (rst && $urandom_range(0, 1) == 0) rst = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        for (int j = 0; j < 4; j++)
          dg[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        dp  = 4'($urandom_range(0, 15));
        bm  = 4'($urandom_range(0, 15));
        lz  = 1'($urandom_range(0, 1));
        dg1 = 4'($urandom_range(0, 15));
        dp1 = 1'($urandom_range(0, 1));
        bm1 = 1'($urandom_range(0, 1));
        lz1 = 1'($urandom_range(0, 1));
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
